// File: rtl/tile_pkg.sv
// Shared encodings and defaults for the tile memory-match game.
// Imported by tile_select and tile_match_core.
package tile_pkg;

    typedef enum logic [1:0] {
        MODE_MENU = 2'd0,
        MODE_PLAY = 2'd1,
        MODE_END  = 2'd2
    } mode_e;

    typedef enum logic [1:0] {
        PLAY_IDLE = 2'd0,
        PLAY_ONE  = 2'd1,
        PLAY_TWO  = 2'd2
    } play_e;

    localparam int REVEAL_DEFAULT = 100000000;

endpackage

// File: rtl/tile_select.sv
// Rising-edge detect on the tile switches and lowest-index pick
// among tiles that are not already shown.
module tile_select #(
    parameter int N_TILES = 10
) (
    input  logic                       CLOCK_50,
    input  logic                       resetn,
    input  logic [N_TILES-1:0]         sel,
    input  logic [N_TILES-1:0]         shown,
    output logic                       found,
    output logic [$clog2(N_TILES)-1:0] index
);

    logic [N_TILES-1:0] sel_q;
    logic [N_TILES-1:0] cand;

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) sel_q <= '0;
        else         sel_q <= sel;
    end

    assign cand = sel & ~sel_q & ~shown;

    // Descending scan so the lowest set bit is the last one written.
    always_comb begin
        found = 1'b0;
        index = '0;
        for (int i = N_TILES - 1; i >= 0; i--) begin
            if (cand[i]) begin
                found = 1'b1;
                index = ($clog2(N_TILES))'(i);
            end
        end
    end

endmodule

// File: rtl/tile_match_core.sv
// Memory-match game core: menu/play/end modes, two-tile reveal
// with a timed display, match scoring and a saturating move count.
module tile_match_core
    import tile_pkg::*;
#(
    parameter int N_TILES       = 10,
    parameter int COLOR_W       = 4,
    parameter int REVEAL_CYCLES = REVEAL_DEFAULT,
    parameter int SCORE_W       = 8
) (
    input  logic                         CLOCK_50,
    input  logic                         resetn,
    input  logic                         start,
    input  logic                         quit,
    input  logic [N_TILES-1:0]           sel,
    input  logic [N_TILES*COLOR_W-1:0]   tile_colors,
    output logic [1:0]                   mode,
    output logic [N_TILES-1:0]           matched,
    output logic [N_TILES-1:0]           shown,
    output logic [COLOR_W-1:0]           first_color,
    output logic [COLOR_W-1:0]           second_color,
    output logic                         first_valid,
    output logic                         second_valid,
    output logic [SCORE_W-1:0]           moves,
    output logic                         match_pulse,
    output logic                         miss_pulse,
    output logic                         game_over
);

    localparam int IW = $clog2(N_TILES);
    localparam int CW = $clog2(REVEAL_CYCLES);
    localparam logic [CW-1:0] CNT_LAST = CW'(REVEAL_CYCLES - 1);

    mode_e              mode_q;
    play_e              play_q;
    logic [IW-1:0]      first_idx, second_idx;
    logic [COLOR_W-1:0] first_col, second_col;
    logic [CW-1:0]      cnt;
    logic [N_TILES-1:0] matched_q;
    logic [SCORE_W-1:0] moves_q;
    logic               match_q, miss_q, over_q;

    logic [N_TILES-1:0] revealed;
    logic [N_TILES-1:0] matched_upd;
    logic [SCORE_W-1:0] moves_inc;
    logic               same_col;
    logic               found;
    logic [IW-1:0]      pick_idx;
    logic [COLOR_W-1:0] pick_col;

    always_comb begin
        revealed = '0;
        if (play_q != PLAY_IDLE) revealed[first_idx]  = 1'b1;
        if (play_q == PLAY_TWO)  revealed[second_idx] = 1'b1;
    end

    assign shown       = matched_q | revealed;
    assign same_col    = (first_col == second_col);
    assign matched_upd = matched_q | (same_col ? revealed : '0);
    assign moves_inc   = (&moves_q) ? moves_q : moves_q + 1'b1;
    assign pick_col    = tile_colors[pick_idx*COLOR_W +: COLOR_W];

    tile_select #(.N_TILES(N_TILES)) u_select (
        .CLOCK_50 (CLOCK_50),
        .resetn   (resetn),
        .sel      (sel),
        .shown    (shown),
        .found    (found),
        .index    (pick_idx)
    );

    always_ff @(posedge CLOCK_50 or negedge resetn) begin
        if (!resetn) begin
            mode_q     <= MODE_MENU;
            play_q     <= PLAY_IDLE;
            first_idx  <= '0;
            second_idx <= '0;
            first_col  <= '0;
            second_col <= '0;
            cnt        <= '0;
            matched_q  <= '0;
            moves_q    <= '0;
            match_q    <= 1'b0;
            miss_q     <= 1'b0;
            over_q     <= 1'b0;
        end else begin
            match_q <= 1'b0;
            miss_q  <= 1'b0;
            if (quit) begin
                mode_q    <= MODE_MENU;
                play_q    <= PLAY_IDLE;
                matched_q <= '0;
                moves_q   <= '0;
                cnt       <= '0;
                over_q    <= 1'b0;
            end else begin
                unique case (mode_q)
                    MODE_MENU: begin
                        play_q <= PLAY_IDLE;
                        if (start) begin
                            mode_q     <= MODE_PLAY;
                            matched_q  <= '0;
                            moves_q    <= '0;
                            cnt        <= '0;
                            first_idx  <= '0;
                            second_idx <= '0;
                            first_col  <= '0;
                            second_col <= '0;
                        end
                    end
                    MODE_PLAY: begin
                        // Final match was recorded last cycle.
                        if (over_q) begin
                            mode_q <= MODE_END;
                            play_q <= PLAY_IDLE;
                        end else begin
                            unique case (play_q)
                                PLAY_IDLE: if (found) begin
                                    play_q    <= PLAY_ONE;
                                    first_idx <= pick_idx;
                                    first_col <= pick_col;
                                end
                                PLAY_ONE: if (found) begin
                                    play_q     <= PLAY_TWO;
                                    second_idx <= pick_idx;
                                    second_col <= pick_col;
                                    cnt        <= '0;
                                end
                                PLAY_TWO: begin
                                    if (cnt == CNT_LAST) begin
                                        cnt       <= '0;
                                        play_q    <= PLAY_IDLE;
                                        moves_q   <= moves_inc;
                                        matched_q <= matched_upd;
                                        match_q   <= same_col;
                                        miss_q    <= !same_col;
                                        over_q    <= &matched_upd;
                                    end else begin
                                        cnt <= cnt + 1'b1;
                                    end
                                end
                                default: play_q <= PLAY_IDLE;
                            endcase
                        end
                    end
                    MODE_END: begin
                        play_q <= PLAY_IDLE;
                        if (start) begin
                            mode_q    <= MODE_MENU;
                            matched_q <= '0;
                            moves_q   <= '0;
                            over_q    <= 1'b0;
                        end
                    end
                    default: mode_q <= MODE_MENU;
                endcase
            end
        end
    end

    assign mode         = mode_q;
    assign matched      = matched_q;
    assign moves        = moves_q;
    assign match_pulse  = match_q;
    assign miss_pulse   = miss_q;
    assign game_over    = over_q;
    assign first_valid  = (play_q == PLAY_ONE) || (play_q == PLAY_TWO);
    assign second_valid = (play_q == PLAY_TWO);
    assign first_color  = first_valid  ? first_col  : '0;
    assign second_color = second_valid ? second_col : '0;

endmodule

// File: tb/tb_tile_match_core.sv
// Scenario bench for tile_match_core; a second instance with a
// 2-bit move counter shares the stimulus to exercise saturation.
module tb_tile_match_core;

    localparam int N   = 4;
    localparam int CWD = 4;
    localparam int REV = 8;

    logic            CLOCK_50 = 1'b0;
    logic            resetn;
    logic            start, quit;
    logic [N-1:0]    sel;
    logic [N*CWD-1:0] tile_colors;

    logic [1:0]     mode, mode_s;
    logic [N-1:0]   matched, shown, matched_s, shown_s;
    logic [CWD-1:0] fcol, scol, fcol_s, scol_s;
    logic           fval, sval, fval_s, sval_s;
    logic [7:0]     moves;
    logic [1:0]     moves_s;
    logic           mp, xp, go, mp_s, xp_s, go_s;

    tile_match_core #(
        .N_TILES(N), .COLOR_W(CWD), .REVEAL_CYCLES(REV), .SCORE_W(8)
    ) dut (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .quit(quit), .sel(sel), .tile_colors(tile_colors),
        .mode(mode), .matched(matched), .shown(shown),
        .first_color(fcol), .second_color(scol),
        .first_valid(fval), .second_valid(sval), .moves(moves),
        .match_pulse(mp), .miss_pulse(xp), .game_over(go)
    );

    tile_match_core #(
        .N_TILES(N), .COLOR_W(CWD), .REVEAL_CYCLES(REV), .SCORE_W(2)
    ) dut_s (
        .CLOCK_50(CLOCK_50), .resetn(resetn), .start(start),
        .quit(quit), .sel(sel), .tile_colors(tile_colors),
        .mode(mode_s), .matched(matched_s), .shown(shown_s),
        .first_color(fcol_s), .second_color(scol_s),
        .first_valid(fval_s), .second_valid(sval_s), .moves(moves_s),
        .match_pulse(mp_s), .miss_pulse(xp_s), .game_over(go_s)
    );

    always #10 CLOCK_50 = ~CLOCK_50;

    int cyc = 0;
    always @(posedge CLOCK_50) cyc <= cyc + 1;

    typedef struct {
        bit         hit;
        logic [3:0] mt;
        logic [7:0] mv;
        logic [1:0] mv2;
        int         due;
    } exp_t;

    exp_t sb[$];
    int   colr[N] = '{1, 2, 1, 2};
    logic [3:0] e_mt;
    logic [7:0] e_mv;
    logic [1:0] e_mv2;
    int checks = 0;
    int errors = 0;

    task automatic step();
        @(posedge CLOCK_50);
        #1;
    endtask

    task automatic model_clear();
        e_mt  = '0;
        e_mv  = '0;
        e_mv2 = '0;
    endtask

    task automatic new_game();
        sel  = '0;
        quit = 1'b1;
        step();
        quit  = 1'b0;
        start = 1'b1;
        step();
        start = 1'b0;
        model_clear();
    endtask

    task automatic push_pair(input int a, input int b);
        exp_t e;
        e.hit = (colr[a] == colr[b]);
        if (e.hit) begin
            e_mt[a] = 1'b1;
            e_mt[b] = 1'b1;
        end
        if (e_mv != 8'hff) e_mv = e_mv + 1;
        if (e_mv2 != 2'b11) e_mv2 = e_mv2 + 1;
        e.mt  = e_mt;
        e.mv  = e_mv;
        e.mv2 = e_mv2;
        e.due = cyc + REV;
        sb.push_back(e);
    endtask

    task automatic do_pair(input int a, input int b);
        sel[a] = 1'b1;
        step();
        sel[b] = 1'b1;
        step();
        push_pair(a, b);
        sel = '0;
    endtask

    task automatic wait_eval(input string nm);
        exp_t e;
        bit   seen = 0;
        for (int k = 0; k < 4 * REV && !seen; k++) begin
            step();
            if (mp || xp) seen = 1;
        end
        checks++;
        if (!seen) begin
            errors++;
            $display("FAIL %s timeout: no pulse", nm);
        end else if (sb.size() == 0) begin
            errors++;
            $display("FAIL %s: pulse with empty scoreboard", nm);
        end else begin
            e = sb.pop_front();
            if ({mp, xp} !== {e.hit, !e.hit}) begin
                errors++;
                $display("FAIL %s pulse: got %b%b want %b%b",
                         nm, mp, xp, e.hit, !e.hit);
            end
            if (matched !== e.mt || moves !== e.mv) begin
                errors++;
                $display("FAIL %s state: mt=%b mv=%0d want %b %0d",
                         nm, matched, moves, e.mt, e.mv);
            end
            if (moves_s !== e.mv2) begin
                errors++;
                $display("FAIL %s moves2: got %0d want %0d",
                         nm, moves_s, e.mv2);
            end
            if (cyc != e.due) begin
                errors++;
                $display("FAIL %s timing: cyc %0d want %0d",
                         nm, cyc, e.due);
            end
        end
    endtask

    task automatic test_reset();
        resetn = 1'b0;
        #5;
        checks++;
        if ({mode, matched, shown, moves, fval, sval, mp, xp, go}
            !== '0 || {fcol, scol} !== '0) begin
            errors++;
            $display("FAIL reset: mode=%0d mt=%b mv=%0d go=%b",
                     mode, matched, moves, go);
        end
        step();
        resetn = 1'b1;
        step();
    endtask

    task automatic test_match();
        new_game();
        checks++;
        if (mode !== 2'd1) begin
            errors++;
            $display("FAIL start: mode %0d want 1", mode);
        end
        sel[0] = 1'b1;
        step();
        checks++;
        if (!fval || fcol !== 4'd1 || shown !== 4'b0001) begin
            errors++;
            $display("FAIL first: v=%b c=%0d sh=%b want 1 1 0001",
                     fval, fcol, shown);
        end
        sel[2] = 1'b1;
        step();
        checks++;
        if (!sval || scol !== 4'd1 || shown !== 4'b0101) begin
            errors++;
            $display("FAIL second: v=%b c=%0d sh=%b want 1 1 0101",
                     sval, scol, shown);
        end
        push_pair(0, 2);
        sel = '0;
        wait_eval("match");
    endtask

    task automatic test_mismatch();
        new_game();
        do_pair(0, 1);
        wait_eval("miss");
        checks++;
        if (shown !== 4'b0000 || fval) begin
            errors++;
            $display("FAIL miss_hide: sh=%b fv=%b want 0000 0",
                     shown, fval);
        end
        sel[0] = 1'b1;
        step();
        checks++;
        if (!fval || sval || shown !== 4'b0001) begin
            errors++;
            $display("FAIL reraise: fv=%b sv=%b sh=%b want 1 0 0001",
                     fval, sval, shown);
        end
        sel = '0;
    endtask

    task automatic test_simultaneous();
        new_game();
        sel = 4'b0110;
        step();
        checks++;
        if (!fval || fcol !== 4'd2 || shown !== 4'b0010) begin
            errors++;
            $display("FAIL simul: v=%b c=%0d sh=%b want 1 2 0010",
                     fval, fcol, shown);
        end
        step();
        checks++;
        if (sval || shown !== 4'b0010) begin
            errors++;
            $display("FAIL held: sv=%b sh=%b want 0 0010", sval, shown);
        end
        sel = 4'b0010;
        step();
        sel = 4'b0110;
        step();
        checks++;
        if (!sval || scol !== 4'd1 || shown !== 4'b0110) begin
            errors++;
            $display("FAIL reraise2: v=%b c=%0d sh=%b want 1 1 0110",
                     sval, scol, shown);
        end
        push_pair(1, 2);
        sel = '0;
        wait_eval("simul_eval");
    endtask

    task automatic test_complete();
        new_game();
        do_pair(0, 2);
        wait_eval("pair_a");
        do_pair(1, 3);
        wait_eval("pair_b");
        checks++;
        if (go !== 1'b1) begin
            errors++;
            $display("FAIL over_flag: got %b want 1", go);
        end
        step();
        checks++;
        if (mode !== 2'd2 || go !== 1'b1 || moves !== 8'd2
            || matched !== 4'b1111) begin
            errors++;
            $display("FAIL end: mode=%0d go=%b mv=%0d mt=%b",
                     mode, go, moves, matched);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        checks++;
        if (mode !== 2'd0 || moves !== 8'd0 || go !== 1'b0) begin
            errors++;
            $display("FAIL to_menu: mode=%0d mv=%0d go=%b want 0 0 0",
                     mode, moves, go);
        end
    endtask

    task automatic test_saturation();
        new_game();
        for (int r = 0; r < 5; r++) begin
            do_pair(0, 1);
            wait_eval("sat_round");
        end
        checks++;
        if (moves_s !== 2'd3 || moves !== 8'd5) begin
            errors++;
            $display("FAIL saturate: m2=%0d m8=%0d want 3 5",
                     moves_s, moves);
        end
    endtask

    task automatic test_abort();
        bit pulsed = 0;
        new_game();
        do_pair(0, 1);
        void'(sb.pop_back());
        repeat (3) step();
        quit  = 1'b1;
        start = 1'b1;
        step();
        quit  = 1'b0;
        start = 1'b0;
        if (mp || xp) pulsed = 1;
        checks++;
        if (mode !== 2'd0 || matched !== '0 || moves !== '0
            || shown !== '0) begin
            errors++;
            $display("FAIL quit: mode=%0d mt=%b mv=%0d sh=%b",
                     mode, matched, moves, shown);
        end
        for (int k = 0; k < 2 * REV; k++) begin
            step();
            if (mp || xp) pulsed = 1;
        end
        checks++;
        if (pulsed || mode !== 2'd0) begin
            errors++;
            $display("FAIL quit_quiet: pulse=%b mode=%0d want 0 0",
                     pulsed, mode);
        end
        start = 1'b1;
        step();
        start = 1'b0;
        do_pair(0, 1);
        void'(sb.pop_back());
        repeat (2) step();
        #3;
        resetn = 1'b0;
        #2;
        checks++;
        if ({mode, matched, shown, moves, fval, sval, mp, xp, go}
            !== '0 || {fcol, scol, moves_s} !== '0) begin
            errors++;
            $display("FAIL async_rst: mode=%0d sh=%b fv=%b sv=%b",
                     mode, shown, fval, sval);
        end
        pulsed = 0;
        for (int k = 0; k < 2 * REV; k++) begin
            step();
            if (mp || xp) pulsed = 1;
        end
        checks++;
        if (pulsed) begin
            errors++;
            $display("FAIL rst_quiet: pulse seen during reset");
        end
        resetn = 1'b1;
        step();
    endtask

    initial begin
        resetn      = 1'b1;
        start       = 1'b0;
        quit        = 1'b0;
        sel         = '0;
        tile_colors = {4'd2, 4'd1, 4'd2, 4'd1};
        model_clear();
        #3;
        test_reset();
        test_match();
        test_mismatch();
        test_simultaneous();
        test_complete();
        test_saturation();
        test_abort();
        checks++;
        if (sb.size() != 0) begin
            errors++;
            $display("FAIL scoreboard: %0d left", sb.size());
        end
        $display("Simulation finished: %0d checks, %0d errors",
                 checks, errors);
        $finish;
    end

endmodule
